// File: rtl/regfile_writeback_buffer_pkg.sv
// Processor constants shared by the register-file writeback path.
// Also holds the (rd, data) entry type that the writeback FIFO stores.
package regfile_writeback_buffer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int REG_COUNT  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_entry_t;

  // Register 0 is hardwired, so it is never stored and never forwarded.
  function automatic logic addr_writable(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/regfile_writeback_buffer_if.sv
// Writeback request channel from the execute/memory stages into the buffer.
// hold travels with the request so the producer side can stall draining.
interface regfile_writeback_buffer_if;
  import regfile_writeback_buffer_pkg::*;

  logic      wb_valid;
  logic      wb_ready;
  reg_addr_t wb_rd;
  reg_data_t wb_data;
  logic      hold;

  modport master (
    output wb_valid,
    output wb_rd,
    output wb_data,
    output hold,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_rd,
    input  wb_data,
    input  hold,
    output wb_ready
  );

endinterface

// File: rtl/regfile_writeback_buffer_forward_mux.sv
// Combinational read forwarding for one register-file read port.
// The newest queued entry wins, then the write-port stage, then the raw RF data.
module regfile_forward_mux
  import regfile_writeback_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic      [PW-1:0]    head,
  input  logic      [CW-1:0]    count,
  input  logic                  out_we,
  input  reg_addr_t             out_rw,
  input  reg_data_t             out_busw,
  input  reg_addr_t             addr,
  input  reg_data_t             rf_data,
  output reg_data_t             fwd_data
);

  logic [PW-1:0] slot;

  // Walk oldest to newest so a later (younger) match overrides an earlier one.
  always_comb begin
    fwd_data = rf_data;
    slot     = '0;
    if (addr_writable(addr)) begin
      if (out_we && (out_rw == addr)) begin
        fwd_data = out_busw;
      end
      for (int i = 0; i < DEPTH; i++) begin
        slot = head + PW'(i);
        if ((CW'(i) < count) && (entries[slot].rd == addr)) begin
          fwd_data = entries[slot].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_buffer.sv
// Write-side master for the 32x32 register file: queues writeback requests,
// drains one per cycle into RW/BusW, and forwards pending values to BusA/BusB.
module regfile_writeback_buffer
  import regfile_writeback_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                         clock,
  input  logic                         reset,
  regfile_writeback_buffer_if.slave    wb,
  output reg_addr_t                    RW,
  output reg_data_t                    BusW,
  output logic                         sig_enable_write,
  input  reg_addr_t                    RA,
  input  reg_addr_t                    RB,
  input  reg_data_t                    BusA_rf,
  input  reg_data_t                    BusB_rf,
  output reg_data_t                    BusA,
  output reg_data_t                    BusB,
  output logic      [CW-1:0]           count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] fifo_mem;
  logic      [PW-1:0]    head;
  logic      [PW-1:0]    tail;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign wb.wb_ready = !full;

  // A request to r0 completes the handshake but is dropped instead of queued.
  assign accept = wb.wb_valid && wb.wb_ready;
  assign push   = accept && addr_writable(wb.wb_rd);
  assign pop    = !wb.hold && !empty;

  // Occupancy is tracked directly; pointer difference cannot tell full from empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[tail].rd   <= wb.wb_rd;
      fifo_mem[tail].data <= wb.wb_data;
    end
  end

  // Write port keeps its last RW/BusW when idle; only the enable drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RW               <= '0;
      BusW             <= '0;
      sig_enable_write <= 1'b0;
    end else if (pop) begin
      RW               <= fifo_mem[head].rd;
      BusW             <= fifo_mem[head].data;
      sig_enable_write <= 1'b1;
    end else begin
      sig_enable_write <= 1'b0;
    end
  end

  regfile_forward_mux #(
    .DEPTH (DEPTH)
  ) u_forward_a (
    .entries  (fifo_mem),
    .head     (head),
    .count    (count),
    .out_we   (sig_enable_write),
    .out_rw   (RW),
    .out_busw (BusW),
    .addr     (RA),
    .rf_data  (BusA_rf),
    .fwd_data (BusA)
  );

  regfile_forward_mux #(
    .DEPTH (DEPTH)
  ) u_forward_b (
    .entries  (fifo_mem),
    .head     (head),
    .count    (count),
    .out_we   (sig_enable_write),
    .out_rw   (RW),
    .out_busw (BusW),
    .addr     (RB),
    .rf_data  (BusB_rf),
    .fwd_data (BusB)
  );

endmodule

// File: doc/regfile_writeback_buffer.md
Name: regfile_writeback_buffer

Overview:
- Write-side master for the processor's 32x32 register file.
- Accepts writeback requests from the execute/memory stages over a valid/ready handshake and queues them in a small FIFO.
- Drains one entry per cycle into the register file write port (RW, BusW, sig_enable_write).
- Forwards the newest pending value for any read address, so read ports BusA/BusB never return stale data while a write is in flight.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy counter (derived, not overridden).

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- wb_valid  input  1  writeback request present.
- wb_ready  output  1  buffer can accept; equals !full.
- wb_rd  input  5  destination register index.
- wb_data  input  32  value to write.
- hold  input  1  when 1, the buffer does not drain this cycle.
- RW  output  5  register file write index (registered).
- BusW  output  32  register file write data (registered).
- sig_enable_write  output  1  register file write enable (registered).
- RA, RB  input  5 each  read addresses, shared with the register file.
- BusA_rf, BusB_rf  input  32 each  raw register file read data.
- BusA, BusB  output  32 each  forwarded read data.
- count  output  CW  current FIFO occupancy.
- empty, full  output  1 each  count==0, count==DEPTH.

Behaviour:
- Reset (async, any time):
  - head, tail and count go to 0.
  - RW=0, BusW=0, sig_enable_write=0.
  - All pending writes are discarded; no partial write reaches the register file.
- Enqueue happens at a rising edge when wb_valid && wb_ready.
  - wb_ready uses count before the edge, so a full buffer rejects input even if it pops in the same cycle.
  - wb_rd==0 is handshaken (consumed) but never enqueued and never forwarded.
- Dequeue happens at a rising edge when !hold && count>0.
  - Head entry loads into RW/BusW, sig_enable_write=1, and head advances.
- If hold || count==0 at the edge, sig_enable_write=0 and RW/BusW hold their previous values.
- Simultaneous enqueue and dequeue: count is unchanged; the new entry goes to the tail.
- Pointers wrap modulo DEPTH; count is tracked explicitly and is never derived from pointer difference.
- Latency with an empty buffer and hold=0:
  - Accepted at edge N.
  - Presented on the write port after edge N+1.
  - Written into the register file at edge N+2.
  - Back-to-back throughput is 1 write per cycle.
- Forwarding is combinational, evaluated for RA→BusA and RB→BusB independently. Priority, highest first:
  1. Newest valid FIFO entry with matching rd (search tail-1 back to head).
  2. Output stage (sig_enable_write && RW==addr).
  3. BusA_rf/BusB_rf.
- Address 0 never matches, so the register file value passes through.
- Forwarding reflects an entry from the cycle after its acceptance edge and stays valid until the register file has committed it.

Decomposition:
- Shared package (processor constants file) holds:
  - REG_ADDR_W=5, DATA_W=32, REG_COUNT=32.
  - The writeback entry pair (rd, data) as a packed type.
- One sub-module: regfile_forward_mux.
  - Pure combinational priority search over FIFO entries plus the output stage.
  - Instantiated twice, once for port A and once for port B.
- FIFO storage and pointers stay in the top module.

Test Plan:
- Reset, then push (rd=1, 16) with hold=0 → after 2 edges: RW=1, BusW=16, sig_enable_write=1 for exactly one cycle; count returns to 0.
- Push rd=2 values 32 then 64 back-to-back with hold=1; RA=2, BusA_rf=0 → BusA=64 while both are queued. Release hold → the write port shows 32 then 64 on consecutive cycles.
- hold=1 and push 5 entries (DEPTH=4) → 4 accepted, wb_ready=0 on the 5th cycle, full=1, count=4; release hold → drains in order, empty=1 after 4 cycles.
- Full buffer with hold dropping and wb_valid=1 on the same edge → no enqueue that edge (wb_ready=0), count goes 4→3; the entry is accepted on the next edge.
- Push (rd=0, 128) → wb_ready=1, count stays 0, sig_enable_write stays 0; RA=0 → BusA equals BusA_rf.
- Push 3 entries with hold=1, assert reset mid-operation → count=0, sig_enable_write=0 immediately; after release of reset, RA=(a queued rd) → BusA equals BusA_rf.
